// File: rtl/remap_inv_pipe.sv
// Log-domain to linear reconstruction: {k, m2} -> un-remap m2 to m1 -> (1.m1) << k.
// Optional antilog correction in stage 1 is enabled by defining REMAP_INV_CORR_EN.
module remap_inv_pipe #(
  parameter int NUM_W = 32,
  parameter int K_W   = 5,
  parameter int M_W   = 27
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NUM_W-1:0] code_i,
  input  logic             code_valid_i,
  output logic             code_ready_o,
  output logic [NUM_W-1:0] rslt_o,
  output logic             rslt_valid_o,
  input  logic             rslt_ready_i
);

  logic [K_W-1:0]   k_p0;
  logic [M_W-1:0]   m2_p0;
  logic [K_W-1:0]   k_p1;
  logic [M_W-1:0]   m1_p1;
  logic             vld_p1;
  logic [NUM_W-1:0] rslt_p2;
  logic             vld_p2;
  logic             s1_adv;
  logic             s2_adv;

  // Un-remap: m1 = m2 - (m2 * (1 - m2)) / 4 in fixed point, or identity.
  function automatic logic [M_W-1:0] unremap(input logic [M_W-1:0] m2);
`ifdef REMAP_INV_CORR_EN
    logic [2*M_W:0] a;
    logic [2*M_W:0] b;
    logic [2*M_W:0] prod;
    a    = {{(M_W+1){1'b0}}, m2};
    b    = {{M_W{1'b0}}, 1'b1, {M_W{1'b0}}} - a;
    prod = a * b;
    return m2 - M_W'(prod >> (M_W + 2));
`else
    return m2;
`endif
  endfunction

  // (1.m1) * 2^k; the widened shift cannot lose the leading one for k < NUM_W.
  function automatic logic [NUM_W-1:0] antilog(input logic [K_W-1:0] k,
                                               input logic [M_W-1:0] m1);
    logic [M_W+NUM_W-1:0] wide;
    wide = {{(NUM_W-1){1'b0}}, 1'b1, m1} << k;
    return NUM_W'(wide >> M_W);
  endfunction

  assign k_p0   = code_i[NUM_W-1 -: K_W];
  assign m2_p0  = code_i[M_W-1:0];

  assign s2_adv       = !vld_p2 || rslt_ready_i;
  assign s1_adv       = !vld_p1 || s2_adv;
  assign code_ready_o = s1_adv;

  // Stage 1: capture exponent and un-remapped mantissa
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      k_p1   <= '0;
      m1_p1  <= '0;
    end else if (s1_adv) begin
      vld_p1 <= code_valid_i;
      if (code_valid_i) begin
        k_p1  <= k_p0;
        m1_p1 <= unremap(m2_p0);
      end
    end
  end

  // Stage 2: shift into the linear domain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p2  <= 1'b0;
      rslt_p2 <= '0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        rslt_p2 <= antilog(k_p1, m1_p1);
      end
    end
  end

  assign rslt_o       = rslt_p2;
  assign rslt_valid_o = vld_p2;

endmodule

// File: tb/tb_remap_inv_pipe.sv
// Directed and randomised bench for remap_inv_pipe (honours REMAP_INV_CORR_EN if defined).
module tb_remap_inv_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] code_i;
  logic        code_valid_i;
  logic        code_ready_o;
  logic [31:0] rslt_o;
  logic        rslt_valid_o;
  logic        rslt_ready_i;

  int checks = 0;
  int errors = 0;

  remap_inv_pipe #(.NUM_W(32), .K_W(5), .M_W(27)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .code_i      (code_i),
    .code_valid_i(code_valid_i),
    .code_ready_o(code_ready_o),
    .rslt_o      (rslt_o),
    .rslt_valid_o(rslt_valid_o),
    .rslt_ready_i(rslt_ready_i)
  );

  always #5 clk_i = ~clk_i;

`ifdef REMAP_INV_CORR_EN
  localparam logic [31:0] EXP_K4  = 32'd23;
  localparam logic [31:0] EXP_K10 = 32'd1232;
`else
  localparam logic [31:0] EXP_K4  = 32'd24;
  localparam logic [31:0] EXP_K10 = 32'd1280;
`endif

  // Reference: 2^k + m1 * 2^(k-27), split by shift direction.
  function automatic logic [31:0] model(input logic [31:0] c);
    int unsigned     k;
    longint unsigned m1;
    longint unsigned r;
`ifdef REMAP_INV_CORR_EN
    longint unsigned p;
`endif
    k  = int'(c[31:27]);
    m1 = 64'(c[26:0]);
`ifdef REMAP_INV_CORR_EN
    p  = m1 * ((64'd1 << 27) - m1);
    m1 = m1 - (p >> 29);
`endif
    if (k <= 27) r = (64'd1 << k) + (m1 >> (27 - k));
    else         r = (64'd1 << k) + (m1 << (k - 27));
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] c, input logic r);
    @(posedge clk_i);
    #1;
    code_valid_i = v;
    code_i       = c;
    rslt_ready_i = r;
  endtask

  task automatic single_xfer(input string tag, input logic [31:0] c, input logic [31:0] exp);
    drive(1'b1, c, 1'b1);
    @(negedge clk_i);
    chk({tag, "_ready"}, 32'(code_ready_o), 32'd1);
    drive(1'b0, 32'hx, 1'b1);
    @(negedge clk_i);
    chk({tag, "_early"}, 32'(rslt_valid_o), 32'd0);
    drive(1'b0, 32'hx, 1'b1);
    @(negedge clk_i);
    chk({tag, "_valid"}, 32'(rslt_valid_o), 32'd1);
    chk({tag, "_data"}, rslt_o, exp);
    drive(1'b0, 32'hx, 1'b1);
    @(negedge clk_i);
    chk({tag, "_dup"}, 32'(rslt_valid_o), 32'd0);
  endtask

  logic [31:0] c2 [3];
  logic [31:0] e2 [3];
  logic [31:0] q [$];
  int          sent;
  int          rcvd;
  logic        acc;
  logic        prev_stall;
  logic [31:0] prev_r;

  initial begin
    rst_i        = 1'b1;
    code_valid_i = 1'b0;
    code_i       = 32'h0;
    rslt_ready_i = 1'b1;

    // Reset state and minimum code
    #12;
    chk("rst_valid", 32'(rslt_valid_o), 32'd0);
    chk("rst_data", rslt_o, 32'd0);
    chk("rst_ready", 32'(code_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    single_xfer("t1_k0", 32'h00000000, 32'h00000001);

    // Back-to-back, full throughput
    c2 = '{32'h24000000, 32'h52000000, 32'hFFFFFFFF};
    e2 = '{EXP_K4, EXP_K10, 32'hFFFFFFF0};
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, (i < 3) ? c2[i] : 32'h0, 1'b1);
      @(negedge clk_i);
      if (i < 3) chk("t2_ready", 32'(code_ready_o), 32'd1);
      if (i >= 2) begin
        chk("t2_valid", 32'(rslt_valid_o), 32'd1);
        chk("t2_data", rslt_o, e2[i-2]);
      end
    end
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk_i);
    chk("t2_drain", 32'(rslt_valid_o), 32'd0);

    // Top exponent and correction-sensitive code
    single_xfer("t3_k31", 32'hF8000000, 32'h80000000);
    single_xfer("t3_k4", 32'h24000000, EXP_K4);

    // Backpressure: two accepted, third held
    drive(1'b1, 32'h18000000, 1'b0);
    @(negedge clk_i);
    chk("t4_rdy1", 32'(code_ready_o), 32'd1);
    drive(1'b1, 32'h38000000, 1'b0);
    @(negedge clk_i);
    chk("t4_rdy2", 32'(code_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0000000, 1'b0);
      @(negedge clk_i);
      chk("t4_rdy3", 32'(code_ready_o), 32'd0);
      chk("t4_hold_valid", 32'(rslt_valid_o), 32'd1);
      chk("t4_hold_data", rslt_o, 32'd8);
    end
    drive(1'b1, 32'hA0000000, 1'b1);
    @(negedge clk_i);
    chk("t4_rel_ready", 32'(code_ready_o), 32'd1);
    chk("t4_out1", rslt_o, 32'd8);
    drive(1'b0, 32'hx, 1'b1);
    @(negedge clk_i);
    chk("t4_v2", 32'(rslt_valid_o), 32'd1);
    chk("t4_out2", rslt_o, 32'd128);
    drive(1'b0, 32'hx, 1'b1);
    @(negedge clk_i);
    chk("t4_v3", 32'(rslt_valid_o), 32'd1);
    chk("t4_out3", rslt_o, 32'h00100000);
    drive(1'b0, 32'hx, 1'b1);
    @(negedge clk_i);
    chk("t4_empty", 32'(rslt_valid_o), 32'd0);

    // Random valid/ready against the reference queue
    sent = 0;
    rcvd = 0;
    acc = 1'b0;
    prev_stall = 1'b0;
    prev_r = 32'h0;
    for (int cyc = 0; cyc < 80000 && rcvd < 10000; cyc++) begin
      @(posedge clk_i);
      #1;
      if (!(code_valid_i && !acc)) begin
        code_valid_i = (sent < 10000) && ($urandom_range(0, 2) != 0);
        code_i       = $urandom;
      end
      rslt_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      if (prev_stall) begin
        chk("t5_stall_valid", 32'(rslt_valid_o), 32'd1);
        chk("t5_stall_data", rslt_o, prev_r);
      end
      acc = code_valid_i && code_ready_o;
      if (acc) begin
        q.push_back(model(code_i));
        sent++;
      end
      if (rslt_valid_o && rslt_ready_i) begin
        if (q.size() == 0) chk("t5_spurious", 32'(rslt_valid_o), 32'd0);
        else chk("t5_data", rslt_o, q.pop_front());
        rcvd++;
      end
      prev_stall = rslt_valid_o && !rslt_ready_i;
      prev_r     = rslt_o;
    end
    chk("t5_count", 32'(rcvd), 32'd10000);
    chk("t5_leftover", 32'(q.size()), 32'd0);

    // Asynchronous reset with two items in flight
    drive(1'b0, 32'hx, 1'b1);
    drive(1'b1, 32'h18000000, 1'b0);
    drive(1'b1, 32'h38000000, 1'b0);
    drive(1'b0, 32'hx, 1'b0);
    @(negedge clk_i);
    chk("t6_inflight", 32'(rslt_valid_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(rslt_valid_o), 32'd0);
    chk("t6_rst_data", rslt_o, 32'd0);
    chk("t6_rst_ready", 32'(code_ready_o), 32'd1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hx, 1'b1);
      @(negedge clk_i);
      chk("t6_stale", 32'(rslt_valid_o), 32'd0);
    end
    single_xfer("t6_after", 32'h60000000, 32'h00001000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
